// File: rtl/axi_cdma_desc_pkg.sv
// Shared definitions for the CDMA descriptor tracker: status error codes and
// the tag-width helper used to size ring indices.
package axi_cdma_desc_pkg;

    localparam logic [3:0] CDMA_ERR_OK      = 4'h0;
    localparam logic [3:0] CDMA_ERR_SLVERR  = 4'h2;
    localparam logic [3:0] CDMA_ERR_DECERR  = 4'h3;
    localparam logic [3:0] CDMA_ERR_TIMEOUT = 4'hE;

    // Tag width for a ring of the given depth; a depth of 1 still needs one bit.
    function automatic int tag_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/axi_cdma_desc_slot_ram.sv
// Per-slot storage for the descriptor tracker: client ID written when a slot
// is allocated, status error written when the mux reports completion.
// The two fields live in separate arrays so both writes can land in the same
// cycle without arbitration. Read is asynchronous at the ring head.
module axi_cdma_desc_slot_ram #(
    parameter int DEPTH     = 8,
    parameter int ID_WIDTH  = 8,
    parameter int TAG_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 alloc_en,
    input  logic [TAG_WIDTH-1:0] alloc_idx,
    input  logic [ID_WIDTH-1:0]  alloc_id,
    input  logic                 stat_en,
    input  logic [TAG_WIDTH-1:0] stat_idx,
    input  logic [3:0]           stat_err,
    input  logic [TAG_WIDTH-1:0] rd_idx,
    output logic [ID_WIDTH-1:0]  rd_id,
    output logic [3:0]           rd_err
);

    logic [ID_WIDTH-1:0] id_mem  [DEPTH];
    logic [3:0]          err_mem [DEPTH];

    // Allocation port: capture the client ID of a newly accepted descriptor.
    always_ff @(posedge clk) begin
        if (alloc_en) id_mem[alloc_idx] <= alloc_id;
    end

    // Status port: capture the error code returned by the mux.
    always_ff @(posedge clk) begin
        if (stat_en) err_mem[stat_idx] <= stat_err;
    end

    assign rd_id  = id_mem[rd_idx];
    assign rd_err = err_mem[rd_idx];

endmodule

// File: rtl/axi_cdma_desc_tracker.sv
// Per-client front end for one CDMA descriptor mux input port.
// Untagged client descriptors get a ring slot as their tag, are forwarded to
// the mux, and their out-of-order status is reported back in issue order.
// Optional feature macro: AXI_CDMA_DESC_TIMEOUT_EN adds a head-of-ring
// watchdog; a timed-out slot becomes a zombie that is not reallocated until
// its late status arrives.
module axi_cdma_desc_tracker
    import axi_cdma_desc_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 16,
    parameter int LEN_WIDTH      = 20,
    parameter int ID_WIDTH       = 8,
    parameter int DEPTH          = 8,
    parameter int TAG_WIDTH      = tag_width(DEPTH),
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axis_desc_read_addr,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axis_desc_write_addr,
    input  logic [LEN_WIDTH-1:0]      s_axis_desc_len,
    input  logic [ID_WIDTH-1:0]       s_axis_desc_id,
    input  logic                      s_axis_desc_valid,
    output logic                      s_axis_desc_ready,
    output logic [AXI_ADDR_WIDTH-1:0] m_axis_desc_read_addr,
    output logic [AXI_ADDR_WIDTH-1:0] m_axis_desc_write_addr,
    output logic [LEN_WIDTH-1:0]      m_axis_desc_len,
    output logic [TAG_WIDTH-1:0]      m_axis_desc_tag,
    output logic                      m_axis_desc_valid,
    input  logic                      m_axis_desc_ready,
    input  logic [TAG_WIDTH-1:0]      s_axis_desc_status_tag,
    input  logic [3:0]                s_axis_desc_status_error,
    input  logic                      s_axis_desc_status_valid,
    output logic [ID_WIDTH-1:0]       m_axis_desc_status_id,
    output logic [3:0]                m_axis_desc_status_error,
    output logic                      m_axis_desc_status_valid,
    input  logic                      m_axis_desc_status_ready
);

    localparam int PTR_W = TAG_WIDTH + 1;

    logic [PTR_W-1:0]     wr_ptr, rd_ptr, count;
    logic [TAG_WIDTH-1:0] wr_idx, rd_idx, st_off;
    logic                 full, empty, out_of_reset;
    logic [DEPTH-1:0]     done, done_nxt, zombie;
    logic                 accept, st_outstanding;
    logic                 retire_slot, retire_done, retire_to, retire;
    logic [ID_WIDTH-1:0]  head_id;
    logic [3:0]           head_err;

    assign wr_idx = wr_ptr[TAG_WIDTH-1:0];
    assign rd_idx = rd_ptr[TAG_WIDTH-1:0];
    assign count  = wr_ptr - rd_ptr;
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_idx == rd_idx) && (wr_ptr[TAG_WIDTH] != rd_ptr[TAG_WIDTH]);

    assign s_axis_desc_ready = out_of_reset && !full && !zombie[wr_idx]
                               && (!m_axis_desc_valid || m_axis_desc_ready);
    assign accept = s_axis_desc_valid && s_axis_desc_ready;

    // A status tag counts only if it lies in the live window [rd_ptr, wr_ptr).
    assign st_off         = s_axis_desc_status_tag - rd_idx;
    assign st_outstanding = s_axis_desc_status_valid && ({1'b0, st_off} < count);

    assign retire_slot = !empty && (!m_axis_desc_status_valid || m_axis_desc_status_ready);
    assign retire_done = retire_slot && done[rd_idx];
    assign retire      = retire_done || retire_to;

`ifdef AXI_CDMA_DESC_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TO_W-1:0] TO_RELOAD = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0]  to_cnt;
    logic             to_run, timeout_hit, st_head_now;
    logic [DEPTH-1:0] zombie_q, zombie_nxt;

    assign to_run      = !empty && !done[rd_idx];
    assign timeout_hit = to_run && (to_cnt == '0);
    assign retire_to   = retire_slot && timeout_hit;
    // Status for the head landing on the very edge it times out is not late.
    assign st_head_now = s_axis_desc_status_valid && (s_axis_desc_status_tag == rd_idx);
    assign zombie      = zombie_q;

    // Watchdog down-counter: runs while the head waits, reloads on every retire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= TO_RELOAD;
        end else if (retire) begin
            to_cnt <= TO_RELOAD;
        end else if (to_run && (to_cnt != '0)) begin
            to_cnt <= to_cnt - 1'b1;
        end
    end

    // Zombie set on timeout retire, cleared by the late status for that tag.
    always_comb begin
        zombie_nxt = zombie_q;
        if (s_axis_desc_status_valid && zombie_q[s_axis_desc_status_tag])
            zombie_nxt[s_axis_desc_status_tag] = 1'b0;
        if (retire_to && !st_head_now)
            zombie_nxt[rd_idx] = 1'b1;
    end

    // Zombie flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) zombie_q <= '0;
        else     zombie_q <= zombie_nxt;
    end
`else
    wire unused_timeout_cfg = |TIMEOUT_CYCLES;

    assign retire_to = 1'b0;
    assign zombie    = '0;
`endif

    // Done flags: set by in-window status, cleared when the slot is reallocated.
    always_comb begin
        done_nxt = done;
        if (st_outstanding) done_nxt[s_axis_desc_status_tag] = 1'b1;
        if (accept)         done_nxt[wr_idx] = 1'b0;
    end

    // Done flags, ring pointers and the reset-release qualifier for ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done         <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            out_of_reset <= 1'b0;
        end else begin
            done         <= done_nxt;
            out_of_reset <= 1'b1;
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (retire) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    axi_cdma_desc_slot_ram #(
        .DEPTH     (DEPTH),
        .ID_WIDTH  (ID_WIDTH),
        .TAG_WIDTH (TAG_WIDTH)
    ) u_slot_ram (
        .clk       (clk),
        .alloc_en  (accept),
        .alloc_idx (wr_idx),
        .alloc_id  (s_axis_desc_id),
        .stat_en   (st_outstanding),
        .stat_idx  (s_axis_desc_status_tag),
        .stat_err  (s_axis_desc_status_error),
        .rd_idx    (rd_idx),
        .rd_id     (head_id),
        .rd_err    (head_err)
    );

    // Descriptor output valid: set on accept, dropped once the mux takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    m_axis_desc_valid <= 1'b0;
        else if (accept)            m_axis_desc_valid <= 1'b1;
        else if (m_axis_desc_ready) m_axis_desc_valid <= 1'b0;
    end

    // Descriptor output payload, tagged with the allocated slot.
    always_ff @(posedge clk) begin
        if (accept) begin
            m_axis_desc_read_addr  <= s_axis_desc_read_addr;
            m_axis_desc_write_addr <= s_axis_desc_write_addr;
            m_axis_desc_len        <= s_axis_desc_len;
            m_axis_desc_tag        <= wr_idx;
        end
    end

    // Status output valid: set on retire, dropped once the client takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           m_axis_desc_status_valid <= 1'b0;
        else if (retire)                   m_axis_desc_status_valid <= 1'b1;
        else if (m_axis_desc_status_ready) m_axis_desc_status_valid <= 1'b0;
    end

    // Status output payload from the head slot; timeouts report their own code.
    always_ff @(posedge clk) begin
        if (retire) begin
            m_axis_desc_status_id    <= head_id;
            m_axis_desc_status_error <= retire_done ? head_err : CDMA_ERR_TIMEOUT;
        end
    end

endmodule
